// File: rtl/hvsync_generator.sv
// VGA raster timing: beam position counters, registered active-low syncs
// and a combinational visible-area flag.
module hvsync_generator #(
    parameter int H_DISPLAY = 640,
    parameter int H_BACK    = 48,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int V_DISPLAY = 480,
    parameter int V_TOP     = 33,
    parameter int V_BOTTOM  = 10,
    parameter int V_SYNC    = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int H_MAX        = H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
    localparam int V_MAX        = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1;

    localparam logic [9:0] HSS  = 10'(H_SYNC_START);
    localparam logic [9:0] HSE  = 10'(H_SYNC_END);
    localparam logic [9:0] HMAX = 10'(H_MAX);
    localparam logic [9:0] HDSP = 10'(H_DISPLAY);
    localparam logic [9:0] VSS  = 10'(V_SYNC_START);
    localparam logic [9:0] VSE  = 10'(V_SYNC_END);
    localparam logic [9:0] VMAX = 10'(V_MAX);
    localparam logic [9:0] VDSP = 10'(V_DISPLAY);

    logic hmaxxed;
    logic vmaxxed;
    logic h_in_sync;
    logic v_in_sync;

    always_comb begin
        hmaxxed   = (hpos == HMAX);
        vmaxxed   = (vpos == VMAX);
        h_in_sync = (hpos >= HSS) && (hpos <= HSE);
        v_in_sync = (vpos >= VSS) && (vpos <= VSE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hpos <= '0;
        end else if (hmaxxed) begin
            hpos <= '0;
        end else begin
            hpos <= hpos + 10'd1;
        end
    end

    // Vertical counter only moves on the last pixel of a line.
    always_ff @(posedge clk) begin
        if (reset) begin
            vpos <= '0;
        end else if (hmaxxed) begin
            if (vmaxxed) begin
                vpos <= '0;
            end else begin
                vpos <= vpos + 10'd1;
            end
        end
    end

    // Syncs are decoded from the pre-edge position, so they trail by one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            hsync <= ~h_in_sync;
            vsync <= ~v_in_sync;
        end
    end

    assign display_on = (hpos < HDSP) && (vpos < VDSP);

endmodule

// File: tb/tb_hvsync_generator.sv
// Bench for hvsync_generator using a shrunken raster so whole frames are cheap.
module tb_hvsync_generator;

    localparam int HD = 16, HB = 4, HF = 2, HS = 6;
    localparam int VD = 12, VT = 3, VB = 2, VS = 2;
    localparam int HSS = HD + HF;
    localparam int HSE = HSS + HS - 1;
    localparam int HMAX = HD + HB + HF + HS - 1;
    localparam int VSS = VD + VB;
    localparam int VSE = VSS + VS - 1;
    localparam int VMAX = VD + VT + VB + VS - 1;
    localparam int LINE = HMAX + 1;
    localparam int FRAME = LINE * (VMAX + 1);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hsync, vsync, display_on;
    logic [9:0] hpos, vpos;

    int total = 0;
    int bad = 0;

    int   mh, mv;
    logic mhs, mvs;
    logic [22:0] sb[$];

    always #5 clk = ~clk;

    hvsync_generator #(
        .H_DISPLAY(HD), .H_BACK(HB), .H_FRONT(HF), .H_SYNC(HS),
        .V_DISPLAY(VD), .V_TOP(VT), .V_BOTTOM(VB), .V_SYNC(VS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hsync(hsync),
        .vsync(vsync),
        .display_on(display_on),
        .hpos(hpos),
        .vpos(vpos)
    );

    // Drive one clock and push the reference outputs for it.
    task automatic tick(input logic r);
        int nh, nv;
        logic nhs, nvs;
        logic [9:0] eh, ev;
        reset = r;
        @(posedge clk);
        if (r) begin
            mh = 0; mv = 0; mhs = 1'b1; mvs = 1'b1;
        end else begin
            nhs = !(mh >= HSS && mh <= HSE);
            nvs = !(mv >= VSS && mv <= VSE);
            nh = (mh == HMAX) ? 0 : mh + 1;
            nv = mv;
            if (mh == HMAX) nv = (mv == VMAX) ? 0 : mv + 1;
            mh = nh; mv = nv; mhs = nhs; mvs = nvs;
        end
        eh = 10'(mh);
        ev = 10'(mv);
        sb.push_back({eh, ev, mhs, mvs, (mh < HD && mv < VD)});
        #1;
    endtask

    task automatic test_reset();
        logic [22:0] exp, got;
        tick(1'b1);
        tick(1'b1);
        repeat (2) begin
            exp = sb.pop_front();
            got = {hpos, vpos, hsync, vsync, display_on};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL reset_sb: got %h want %h", got, exp);
            end
        end
        total++;
        if ({hpos, vpos, hsync, vsync, display_on} !== {10'd0, 10'd0, 3'b111}) begin
            bad++;
            $display("FAIL reset_state: got h=%0d v=%0d hs=%b vs=%b de=%b want 0 0 1 1 1",
                     hpos, vpos, hsync, vsync, display_on);
        end
        tick(1'b0);
        exp = sb.pop_front();
        got = {hpos, vpos, hsync, vsync, display_on};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL reset_next_sb: got %h want %h", got, exp);
        end
        total++;
        if (hpos !== 10'd1) begin
            bad++;
            $display("FAIL reset_next_h: got %0d want 1", hpos);
        end
    endtask

    task automatic test_line_wrap();
        logic [22:0] exp, got;
        logic [9:0] prev_h;
        int low_cnt = 0;
        int first_low = -1;
        int rise_at = -1;
        logic prev_hs;
        prev_hs = hsync;
        for (int i = 0; i < LINE; i++) begin
            prev_h = hpos;
            tick(1'b0);
            exp = sb.pop_front();
            got = {hpos, vpos, hsync, vsync, display_on};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL line_sb: got %h want %h", got, exp);
            end
            if (!hsync) low_cnt++;
            if (prev_hs && !hsync && first_low < 0) first_low = int'(hpos);
            if (!prev_hs && hsync && rise_at < 0) rise_at = int'(hpos);
            prev_hs = hsync;
            if (prev_h == 10'(HMAX)) begin
                total++;
                if (hpos !== 10'd0 || vpos !== 10'd1) begin
                    bad++;
                    $display("FAIL line_wrap: got h=%0d v=%0d want 0 1", hpos, vpos);
                end
            end
        end
        total++;
        if (low_cnt != HS) begin
            bad++;
            $display("FAIL hsync_width: got %0d want %0d", low_cnt, HS);
        end
        total++;
        if (first_low != HSS + 1) begin
            bad++;
            $display("FAIL hsync_fall: got %0d want %0d", first_low, HSS + 1);
        end
        total++;
        if (rise_at != HSE + 2) begin
            bad++;
            $display("FAIL hsync_rise: got %0d want %0d", rise_at, HSE + 2);
        end
    endtask

    task automatic test_frame_wrap();
        logic [22:0] exp, got;
        int de_cnt = 0;
        int run = 0;
        int best = 0;
        int start_h = -1, start_v = -1;
        tick(1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < FRAME; i++) begin
            tick(1'b0);
            exp = sb.pop_front();
            got = {hpos, vpos, hsync, vsync, display_on};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL frame_sb: got %h want %h", got, exp);
            end
            if (display_on) de_cnt++;
            if (!vsync) begin
                if (run == 0 && start_h < 0) begin
                    start_h = int'(hpos);
                    start_v = int'(vpos);
                end
                run++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
            if ((mh == HD - 1 && mv == VD - 1) || (mh == 0 && mv == 0)) begin
                total++;
                if (display_on !== 1'b1) begin
                    bad++;
                    $display("FAIL vis_on: at %0d,%0d got %b want 1", mh, mv, display_on);
                end
            end
            if ((mh == HD && mv == 0) || (mh == 0 && mv == VD)) begin
                total++;
                if (display_on !== 1'b0) begin
                    bad++;
                    $display("FAIL vis_off: at %0d,%0d got %b want 0", mh, mv, display_on);
                end
            end
        end
        total++;
        if (hpos !== 10'd0 || vpos !== 10'd0) begin
            bad++;
            $display("FAIL frame_wrap: got h=%0d v=%0d want 0 0", hpos, vpos);
        end
        total++;
        if (de_cnt != HD * VD) begin
            bad++;
            $display("FAIL active_cnt: got %0d want %0d", de_cnt, HD * VD);
        end
        total++;
        if (best != VS * LINE) begin
            bad++;
            $display("FAIL vsync_width: got %0d want %0d", best, VS * LINE);
        end
        total++;
        if (start_h != 1 || start_v != VSS) begin
            bad++;
            $display("FAIL vsync_start: got %0d,%0d want 1,%0d", start_h, start_v, VSS);
        end
    endtask

    task automatic test_mid_reset();
        logic [22:0] exp, got;
        bit found = 0;
        for (int i = 0; i < FRAME && !found; i++) begin
            tick(1'b0);
            exp = sb.pop_front();
            got = {hpos, vpos, hsync, vsync, display_on};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL mid_seek_sb: got %h want %h", got, exp);
            end
            if (mh == 10 && mv == 5) found = 1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL mid_seek: got timeout want position 10,5");
        end
        tick(1'b1);
        exp = sb.pop_front();
        got = {hpos, vpos, hsync, vsync, display_on};
        total++;
        if (got !== {10'd0, 10'd0, 3'b111} || got !== exp) begin
            bad++;
            $display("FAIL mid_reset: got %h want %h", got, exp);
        end
        for (int i = 0; i < 2 * LINE; i++) begin
            tick(1'b0);
            exp = sb.pop_front();
            got = {hpos, vpos, hsync, vsync, display_on};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL mid_after_sb: got %h want %h", got, exp);
            end
            if (i == LINE - 1) begin
                total++;
                if (hpos !== 10'd0 || vpos !== 10'd1) begin
                    bad++;
                    $display("FAIL mid_line_len: got h=%0d v=%0d want 0 1", hpos, vpos);
                end
            end
        end
    endtask

    task automatic test_reset_in_sync();
        logic [22:0] exp, got;
        bit found = 0;
        int n = 0;
        for (int i = 0; i < FRAME && !found; i++) begin
            tick(1'b0);
            void'(sb.pop_front());
            if (mv == VSS && !mhs) found = 1;
        end
        total++;
        if (!found || hsync !== 1'b0 || vsync !== 1'b0) begin
            bad++;
            $display("FAIL sync_seek: got found=%0d hs=%b vs=%b want 1 0 0",
                     found, hsync, vsync);
        end
        tick(1'b1);
        void'(sb.pop_front());
        total++;
        if (hsync !== 1'b1 || vsync !== 1'b1) begin
            bad++;
            $display("FAIL sync_reset: got hs=%b vs=%b want 1 1", hsync, vsync);
        end
        found = 0;
        for (int i = 0; i < FRAME && !found; i++) begin
            tick(1'b0);
            n++;
            exp = sb.pop_front();
            got = {hpos, vpos, hsync, vsync, display_on};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL sync_after_sb: got %h want %h", got, exp);
            end
            if (vsync === 1'b0) found = 1;
        end
        total++;
        if (n != VSS * LINE + 1 || hpos !== 10'd1 || vpos !== 10'(VSS)) begin
            bad++;
            $display("FAIL sync_refall: got n=%0d at %0d,%0d want n=%0d at 1,%0d",
                     n, hpos, vpos, VSS * LINE + 1, VSS);
        end
    endtask

    initial begin
        test_reset();
        test_line_wrap();
        test_frame_wrap();
        test_mid_reset();
        test_reset_in_sync();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
